// File: rtl/mario_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : mario_pkg
// Description : Shared types and widths for the Mario motion/control slice.
//               Holds the motion FSM state type, datapath widths, the accel
//               width shared with the control FSM, and a velocity saturator.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
package mario_pkg;

  localparam int POS_W = 10;  // screen position width (unsigned)
  localparam int VEL_W = 6;   // velocity width (two's complement)
  localparam int ACC_W = 3;   // acceleration magnitude width (unsigned)

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    VEL   = 3'd1,
    POS   = 3'd2,
    CLAMP = 3'd3,
    DONE  = 3'd4
  } motion_state_t;

  // Clamp an 8-bit signed intermediate velocity to [-i_lim, +i_lim] and
  // narrow it to the stored velocity width.
  function automatic logic signed [VEL_W-1:0] sat_vel(input logic signed [7:0] i_v,
                                                      input int                i_lim);
    logic signed [7:0] w_lim;
    logic signed [7:0] w_res;
    w_lim = 8'(i_lim);
    if (i_v > w_lim) begin
      w_res = w_lim;
    end else if (i_v < -w_lim) begin
      w_res = -w_lim;
    end else begin
      w_res = i_v;
    end
    return w_res[VEL_W-1:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/mario_motion_frame_edge.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : frame_edge
// Description : Single-register rising-edge detector for the vsync-derived
//               frame level. o_tick is high for the one Clk cycle in which
//               i_level is high and was low the cycle before.
// Ports       : Clk     - system clock
//               Reset   - synchronous, active-high
//               i_level - frame level, synchronous to Clk
//               o_tick  - rising-edge pulse (combinational from i_level)
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module frame_edge (
  input  logic Clk,
  input  logic Reset,
  input  logic i_level,
  output logic o_tick
);

  logic r_level_q;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_level_q <= 1'b0;
    end else begin
      r_level_q <= i_level;
    end
  end

  assign o_tick = i_level & ~r_level_q;

endmodule
`default_nettype wire

// File: rtl/mario_motion.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : mario_motion
// Description : Per-frame motion integrator for Mario. On each frame tick it
//               steps VEL -> POS -> CLAMP -> DONE, updating velocity from the
//               control FSM's accelerations, integrating position, and
//               clamping to the playfield. All arithmetic saturates.
// Ports       : Clk            - system clock
//               Reset          - synchronous, active-high
//               i_frame_clk    - vsync-derived level, synchronous to Clk
//               i_right_accel  - rightward accel magnitude (ACC_W)
//               i_left_accel   - leftward accel magnitude (ACC_W)
//               i_up_accel     - upward accel magnitude (ACC_W)
//               i_down_accel   - downward accel magnitude (ACC_W)
//               i_stand_still  - apply friction to X velocity
//               o_pos_x/o_pos_y- unsigned position, Y grows downward
//               o_vel_x/o_vel_y- signed velocity
//               o_is_ground    - Mario rests on the floor
//               o_facing_left  - sprite orientation
//               o_update_done  - one-cycle pulse when frame values are valid
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module mario_motion
  import mario_pkg::*;
#(
  parameter int START_X  = 100,
  parameter int GROUND_Y = 400,
  parameter int X_MIN    = 0,
  parameter int X_MAX    = 620,
  parameter int Y_MIN    = 0,
  parameter int VX_MAX   = 4,
  parameter int VY_MAX   = 8,
  parameter int GRAVITY  = 1
) (
  input  logic                    Clk,
  input  logic                    Reset,
  input  logic                    i_frame_clk,
  input  logic [ACC_W-1:0]        i_right_accel,
  input  logic [ACC_W-1:0]        i_left_accel,
  input  logic [ACC_W-1:0]        i_up_accel,
  input  logic [ACC_W-1:0]        i_down_accel,
  input  logic                    i_stand_still,
  output logic [POS_W-1:0]        o_pos_x,
  output logic [POS_W-1:0]        o_pos_y,
  output logic signed [VEL_W-1:0] o_vel_x,
  output logic signed [VEL_W-1:0] o_vel_y,
  output logic                    o_is_ground,
  output logic                    o_facing_left,
  output logic                    o_update_done
);

  localparam logic signed [7:0]  c_GRAVITY = 8'(GRAVITY);
  localparam logic signed [11:0] c_X_MIN   = 12'(X_MIN);
  localparam logic signed [11:0] c_X_MAX   = 12'(X_MAX);
  localparam logic signed [11:0] c_Y_MIN   = 12'(Y_MIN);
  localparam logic signed [11:0] c_GND_Y   = 12'(GROUND_Y);

  logic                    w_tick;
  motion_state_t           r_state;
  logic signed [11:0]      r_px_sum;
  logic signed [11:0]      r_py_sum;

  frame_edge u_frame_edge (
    .Clk     (Clk),
    .Reset   (Reset),
    .i_level (i_frame_clk),
    .o_tick  (w_tick)
  );

  // Velocity datapath: 8-bit signed intermediates so nothing wraps before
  // saturation.
  logic signed [7:0]       w_vx_ext;
  logic signed [7:0]       w_vy_ext;
  logic signed [7:0]       w_right;
  logic signed [7:0]       w_left;
  logic signed [7:0]       w_up;
  logic signed [7:0]       w_down;
  logic signed [7:0]       w_vx_fric;
  logic signed [7:0]       w_vx_raw;
  logic signed [7:0]       w_vy_raw;
  logic signed [VEL_W-1:0] w_vx_new;
  logic signed [VEL_W-1:0] w_vy_new;
  logic                    w_friction;

  assign w_vx_ext = 8'(o_vel_x);
  assign w_vy_ext = 8'(o_vel_y);
  assign w_right  = $signed({{(8-ACC_W){1'b0}}, i_right_accel});
  assign w_left   = $signed({{(8-ACC_W){1'b0}}, i_left_accel});
  assign w_up     = $signed({{(8-ACC_W){1'b0}}, i_up_accel});
  assign w_down   = $signed({{(8-ACC_W){1'b0}}, i_down_accel});

  // Friction only applies when no horizontal push is requested; it moves the
  // velocity a single step toward zero.
  assign w_friction = i_stand_still && (i_right_accel == '0) && (i_left_accel == '0);
  assign w_vx_fric  = (w_vx_ext > 8'sd0) ? (w_vx_ext - 8'sd1) :
                      (w_vx_ext < 8'sd0) ? (w_vx_ext + 8'sd1) : 8'sd0;
  assign w_vx_raw   = w_friction ? w_vx_fric : (w_vx_ext + w_right - w_left);

  // Standing on the floor without a jump request pins vertical speed to zero
  // so gravity does not accumulate while grounded.
  assign w_vy_raw = (o_is_ground && (i_up_accel == '0)) ? 8'sd0 :
                    (w_vy_ext + w_down + c_GRAVITY - w_up);

  assign w_vx_new = sat_vel(w_vx_raw, VX_MAX);
  assign w_vy_new = sat_vel(w_vy_raw, VY_MAX);

  // Position datapath: 12-bit signed so an overshoot past the left wall or
  // ceiling is representable before clamping.
  logic signed [11:0] w_px_sum;
  logic signed [11:0] w_py_sum;

  assign w_px_sum = $signed({{(12-POS_W){1'b0}}, o_pos_x}) + 12'(o_vel_x);
  assign w_py_sum = $signed({{(12-POS_W){1'b0}}, o_pos_y}) + 12'(o_vel_y);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state       <= IDLE;
      r_px_sum      <= '0;
      r_py_sum      <= '0;
      o_pos_x       <= POS_W'(START_X);
      o_pos_y       <= POS_W'(GROUND_Y);
      o_vel_x       <= '0;
      o_vel_y       <= '0;
      o_is_ground   <= 1'b1;
      o_facing_left <= 1'b0;
      o_update_done <= 1'b0;
    end else begin
      o_update_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_tick) begin
            r_state <= VEL;
          end
        end
        VEL: begin
          o_vel_x <= w_vx_new;
          o_vel_y <= w_vy_new;
          if (w_vx_new < 0) begin
            o_facing_left <= 1'b1;
          end else if (w_vx_new > 0) begin
            o_facing_left <= 1'b0;
          end
          r_state <= POS;
        end
        POS: begin
          r_px_sum <= w_px_sum;
          r_py_sum <= w_py_sum;
          r_state  <= CLAMP;
        end
        CLAMP: begin
          if (r_px_sum < c_X_MIN) begin
            o_pos_x <= POS_W'(X_MIN);
            o_vel_x <= '0;
          end else if (r_px_sum > c_X_MAX) begin
            o_pos_x <= POS_W'(X_MAX);
            o_vel_x <= '0;
          end else begin
            o_pos_x <= r_px_sum[POS_W-1:0];
          end

          if (r_py_sum >= c_GND_Y) begin
            o_pos_y     <= POS_W'(GROUND_Y);
            o_vel_y     <= '0;
            o_is_ground <= 1'b1;
          end else if (r_py_sum < c_Y_MIN) begin
            o_pos_y     <= POS_W'(Y_MIN);
            o_vel_y     <= '0;
            o_is_ground <= 1'b0;
          end else begin
            o_pos_y     <= r_py_sum[POS_W-1:0];
            o_is_ground <= 1'b0;
          end

          o_update_done <= 1'b1;
          r_state       <= DONE;
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/mario_motion.md
# mario_motion

Per-frame motion integrator for Mario, directly downstream of the Mario control FSM. It consumes that FSM's `right_accel`, `left_accel`, `up_accel`, `down_accel` and `stand_still` outputs once per video frame and produces Mario's velocity and screen position. It also produces the `is_ground` flag that the control FSM consumes. All arithmetic is saturating and bounded to the playfield so the sprite renderer can use the outputs directly.

## Interface
- `START_X`, 100: X position after reset.
- `GROUND_Y`, 400: floor Y; also Y position after reset.
- `X_MIN`, 0: left wall.
- `X_MAX`, 620: right wall.
- `Y_MIN`, 0: ceiling.
- `VX_MAX`, 4: horizontal speed limit, magnitude.
- `VY_MAX`, 8: vertical speed limit, magnitude.
- `GRAVITY`, 1: added to `vel_y` every frame.

Ports:
- `Clk`  in  1  system clock.
- `Reset`  in  1  synchronous, active-high.
- `frame_clk`  in  1  vsync-derived level, synchronous to `Clk`.
- `right_accel`, `left_accel`, `up_accel`, `down_accel`  in  3 each  unsigned acceleration magnitudes.
- `stand_still`  in  1  apply friction to X.
- `pos_x`, `pos_y`  out  10  unsigned position; Y grows downward.
- `vel_x`, `vel_y`  out  6  signed, two's complement.
- `is_ground`  out  1  Mario rests on the floor.
- `facing_left`  out  1  sprite orientation.
- `update_done`  out  1  one-cycle pulse when the new frame values are valid.

## Operation
- Frame tick: `tick = frame_clk & ~frame_clk_q`, where `frame_clk_q` is `frame_clk` delayed by one `Clk` cycle.
- FSM states: IDLE, VEL, POS, CLAMP, DONE.
  - IDLE→VEL on `tick`.
  - VEL→POS→CLAMP→DONE→IDLE unconditionally.
  - A `tick` seen outside IDLE is ignored.
- VEL state: sample the accel inputs and compute the new velocities.
  - X:
    - `vx' = vel_x + right_accel - left_accel`.
    - If `stand_still` and both X accels are 0, move `vel_x` one step toward 0 instead.
    - Saturate to [-VX_MAX, +VX_MAX].
  - Y:
    - If `is_ground` and `up_accel == 0`, then `vy' = 0`.
    - Otherwise `vy' = vel_y + down_accel + GRAVITY - up_accel`.
    - Saturate to [-VY_MAX, +VY_MAX].
  - Intermediate sums use at least 8-bit signed arithmetic; there is no wrap before saturation.
  - `facing_left`: set if `vx' < 0`, cleared if `vx' > 0`, held if `vx' == 0`.
- POS state: `px' = pos_x + vel_x` and `py' = pos_y + vel_y`.
  - Computed in 12-bit signed arithmetic, so a negative intermediate result is representable.
- CLAMP state (X):
  - `px' < X_MIN` → `pos_x = X_MIN`, `vel_x = 0`.
  - `px' > X_MAX` → `pos_x = X_MAX`, `vel_x = 0`.
- CLAMP state (Y):
  - `py' >= GROUND_Y` → `pos_y = GROUND_Y`, `vel_y = 0`, `is_ground = 1`.
  - `py' < Y_MIN` → `pos_y = Y_MIN`, `vel_y = 0`, `is_ground = 0`.
  - Otherwise → `is_ground = 0`.
- Reset values: `pos_x = START_X`, `pos_y = GROUND_Y`, `vel_x = vel_y = 0`, `is_ground = 1`, `facing_left = 0`, `update_done = 0`, FSM = IDLE, `frame_clk_q = 0`.
- Reset mid-update (any non-IDLE state): the next cycle has all reset values, and `update_done` does not pulse for the aborted frame.

## Timing
- `tick` is high in cycle T, with the FSM in IDLE.
- VEL is in cycle T+1, POS in T+2, CLAMP in T+3.
- Outputs are final from T+4 onward; `update_done` is high for cycle T+4 only (DONE state).
- Accel inputs must be stable during cycle T+1 only.
- All outputs are registered and change only at clock edges in VEL (velocity, `facing_left`), POS and CLAMP.
- Minimum frame spacing: 5 `Clk` cycles.

## Structure
- Package `mario_pkg` holds:
  - the `motion_state_t` enum (IDLE, VEL, POS, CLAMP, DONE);
  - the `POS_W = 10` and `VEL_W = 6` localparams;
  - the accel width constant `ACC_W = 3`, shared with the control FSM.
- Sub-module `frame_edge`: one-register rising-edge detector that produces `tick`. It resets synchronously.
- Everything else stays in `mario_motion`.

## Test plan
Default parameters throughout.
- Reset → `pos = (100, 400)`, `vel = (0, 0)`, `is_ground = 1`, `facing_left = 0`, no `update_done`.
- `right_accel = 2` held for 3 frames:
  - `vel_x` = 2, 4, 4;
  - `pos_x` = 102, 106, 110;
  - `update_done` at T+4 of each frame;
  - `facing_left = 0`.
- `up_accel = 6` for one frame from ground, then 0:
  - `vel_y` = -5, -4, -3, -2, -1, 0, 1, 2, 3, 4, 5;
  - `pos_y` = 395, 391, 388, 386, 385, 385, 386, 388, 391, 395, 400;
  - final `vel_y = 0`, `is_ground = 1`.
- Friction and wall clamp:
  - At `pos_x = 618`, `vel_x = 4` → `pos_x = 620`, `vel_x = 0`.
  - Then `left_accel = 1` → `facing_left = 1`.
  - Then `stand_still` with `vel_x = -1` → `vel_x = 0`, `facing_left` stays 1.
- Saturation: `down_accel = 7` with Mario airborne (`pos_y = 100`, `vel_y = 0`) → `vel_y = 8` and stays at 8 on later frames.
- Reset asserted in cycle T+2 of a frame with `right_accel = 3` → next cycle shows all reset values, no `update_done` pulse, and the next tick behaves as from reset.
